// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the instruction memory. Takes a program as a byte stream over a
//   valid/ready handshake and packs each byte pair into a 16-bit word, high byte
//   first. Words go to consecutive word addresses starting at 0. The CPU is held
//   until the terminating END_WORD has been written.
//
// Parameters
//   ADDR_WIDTH  word-address width of the instruction memory
//   MAX_WORDS   words accepted before overflow (must be <= 2**ADDR_WIDTH)
//   END_WORD    terminator word; it is written, then loading stops
//
// Ports
//   clock       system clock, all state changes on posedge
//   reset_n     synchronous active-low reset
//   start       begin a load (honoured only when not busy)
//   rx_data     incoming program byte
//   rx_valid    rx_data valid
//   rx_ready    loader accepts a byte this cycle
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_waddr  word address of the write
//   imem_wdata  word being written
//   word_count  words written in the current/last load
//   busy        load in progress
//   done        END_WORD stored; sticky until next start/reset
//   overflow    MAX_WORDS written without END_WORD; sticky until next start/reset
//   cpu_hold    1 = CPU PC must not advance (low only once loading is done)

module imem_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          MAX_WORDS  = 1024,
    parameter logic [15:0] END_WORD   = 16'hFFFF
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [15:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  cpu_hold
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [7:0]              hi_byte;
    logic [7:0]              hi_byte_next;
    logic [ADDR_WIDTH:0]     count_next;
    logic [ADDR_WIDTH:0]     count_inc;
    logic [ADDR_WIDTH-1:0]   waddr_next;
    logic [15:0]             wdata_next;
    logic                    rx_ready_next;
    logic                    imem_we_next;
    logic                    busy_next;
    logic                    done_next;
    logic                    overflow_next;
    logic                    cpu_hold_next;
    logic                    transfer;

    // rx_ready is itself a register, so a transfer is decided from current state only.
    assign transfer  = rx_valid & rx_ready;
    assign count_inc = word_count + 1'b1;

    always_comb begin
        state_next   = state;
        hi_byte_next = hi_byte;
        count_next   = word_count;
        waddr_next   = imem_waddr;
        wdata_next   = imem_wdata;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_next = S_HIGH;
                    count_next = '0;
                end
            end
            S_HIGH: begin
                if (transfer) begin
                    hi_byte_next = rx_data;
                    state_next   = S_LOW;
                end
            end
            S_LOW: begin
                if (transfer) begin
                    wdata_next = {hi_byte, rx_data};
                    waddr_next = word_count[ADDR_WIDTH-1:0];
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                count_next = count_inc;
                // Terminator wins over overflow, so END_WORD as the last allowed word is a clean finish.
                if (imem_wdata == END_WORD) begin
                    state_next = S_DONE;
                end else if (count_inc == MAX_COUNT) begin
                    state_next = S_ERROR;
                end else begin
                    state_next = S_HIGH;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are a decode of the next state and get registered alongside it,
        // so every output is a flop and lines up with the state it describes.
        rx_ready_next = (state_next == S_HIGH) || (state_next == S_LOW);
        imem_we_next  = (state_next == S_WRITE);
        busy_next     = (state_next == S_HIGH) || (state_next == S_LOW) ||
                        (state_next == S_WRITE);
        done_next     = (state_next == S_DONE);
        overflow_next = (state_next == S_ERROR);
        cpu_hold_next = (state_next != S_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            hi_byte    <= '0;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state      <= state_next;
            hi_byte    <= hi_byte_next;
            rx_ready   <= rx_ready_next;
            imem_we    <= imem_we_next;
            imem_waddr <= waddr_next;
            imem_wdata <= wdata_next;
            word_count <= count_next;
            busy       <= busy_next;
            done       <= done_next;
            overflow   <= overflow_next;
            cpu_hold   <= cpu_hold_next;
        end
    end

endmodule
